search_window_scanner: RTL

Producer side of the block-matching distance stream. Accepts one reference block (binary/census bits), then a search window row by row. Scans every candidate offset and emits per-candidate XOR map, Hamming distance, coordinates and block index, one per cycle, on the `xors`/`sum`/`out_coords`/`blk_index_o`/`sum_valid` stream that the minimum-distance stage consumes.

---
 rtl/block_match_pkg.sv | 14 +
 rtl/popcount_tree.sv | 18 +
 rtl/search_window_scanner.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/block_match_pkg.sv
// Shared types for the block-matching distance stream: candidate coordinates,
// scanner state and the 8-bit Hamming distance.
package block_match_pkg;

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] h;
  } coord_t;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DRAIN} scan_state_e;

  typedef logic [7:0] dist_t;

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of the candidate XOR map.
// The scanner registers the result in its second pipeline stage.
module popcount_tree
  import block_match_pkg::*;
#(
  parameter int width = 64
) (
  input  logic [width-1:0] bits_i,
  output dist_t            cnt_o
);

  // Linear accumulation; synthesis rebalances this into an adder tree.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < width; i++) cnt_o = cnt_o + dist_t'(bits_i[i]);
  end

endmodule

// File: rtl/search_window_scanner.sv
// Loads a reference block and a search window, then streams one XOR map,
// Hamming distance and coordinate per cycle over every candidate offset.
module search_window_scanner
  import block_match_pkg::*;
#(
  parameter int blk_h        = 8,
  parameter int blk_w        = 8,
  parameter int search_blk_w = 40,
  parameter int search_blk_h = 12,
  parameter int blk_size     = blk_h * blk_w
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [blk_size-1:0]     ref_blk,
  input  logic [15:0]             ref_index,
  input  logic                    ref_valid,
  output logic                    ref_ready,
  input  logic [search_blk_w-1:0] row_data,
  input  logic                    row_valid,
  output logic                    row_ready,
  output logic [blk_size-1:0]     xors,
  output logic [7:0]              sum,
  output logic [15:0]             out_coords,
  output logic [15:0]             blk_index_o,
  output logic                    sum_valid,
  output logic                    busy
);

  localparam int NV = search_blk_h - blk_h;
  localparam int NH = search_blk_w - blk_w;
  localparam int RW = $clog2(search_blk_h);

  if (blk_size > 255 || blk_size != blk_h * blk_w) begin : g_chk_size
    $error("blk_size must equal blk_h*blk_w and be <= 255");
  end
  if (NV < 1 || NV > 256 || NH < 1 || NH > 256) begin : g_chk_range
    $error("search window must exceed block by 1..256 in each direction");
  end

  scan_state_e state_q, state_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  coord_t        cand_q, cand_d;
  logic          drain_q, drain_d;
  logic          ref_load, row_wr, issue;

  logic [blk_size-1:0]     ref_q;
  logic [15:0]             idx_q;
  logic [search_blk_w-1:0] rowbuf_q [search_blk_h];

  logic [blk_size-1:0] win_x, x1_q, xors_q;
  coord_t              c1_q, coords_q;
  dist_t               pc, sum_q;
  logic [15:0]         bidx_q;
  logic [1:0]          vld_pipe_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      cand_q    <= '0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      cand_q    <= cand_d;
      drain_q   <= drain_d;
    end
  end

  // Next state: v ascends outer, h descends inner
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    cand_d    = cand_q;
    drain_d   = drain_q;
    case (state_q)
      IDLE: if (ref_valid) begin
        state_d   = LOAD;
        row_cnt_d = '0;
      end
      LOAD: if (row_valid) begin
        row_cnt_d = row_cnt_q + 1'b1;
        if (row_cnt_q == RW'(search_blk_h - 1)) begin
          state_d = SCAN;
          cand_d  = '{v: 8'd0, h: 8'(NH - 1)};
        end
      end
      SCAN: begin
        if (cand_q.h == 8'd0) begin
          if (cand_q.v == 8'(NV - 1)) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end else begin
            cand_d.v = cand_q.v + 8'd1;
            cand_d.h = 8'(NH - 1);
          end
        end else begin
          cand_d.h = cand_q.h - 8'd1;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ref_ready = (state_q == IDLE);
    row_ready = (state_q == LOAD);
    busy      = (state_q != IDLE);
    ref_load  = ref_ready & ref_valid;
    row_wr    = row_ready & row_valid;
    issue     = (state_q == SCAN);
  end

  for (genvar r = 0; r < blk_h; r++) begin : g_row
    logic [RW-1:0]    ridx;
    logic [blk_w-1:0] sh;
    assign ridx = RW'(32'(cand_q.v) + 32'(r));
    assign sh   = blk_w'(rowbuf_q[ridx] >> cand_q.h);
    assign win_x[r*blk_w +: blk_w] = ref_q[r*blk_w +: blk_w] ^ sh;
  end

  popcount_tree #(.width(blk_size)) u_pop (
    .bits_i (x1_q),
    .cnt_o  (pc)
  );

  // Stage 1 registers the XOR map, stage 2 the popcount; all output fields
  // load together and hold while no candidate is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_q      <= '0;
      idx_q      <= '0;
      rowbuf_q   <= '{default: '0};
      vld_pipe_q <= '0;
      x1_q       <= '0;
      c1_q       <= '0;
      xors_q     <= '0;
      sum_q      <= '0;
      coords_q   <= '0;
      bidx_q     <= '0;
    end else begin
      if (ref_load) begin
        ref_q <= ref_blk;
        idx_q <= ref_index;
      end
      if (row_wr) rowbuf_q[row_cnt_q] <= row_data;
      vld_pipe_q <= {vld_pipe_q[0], issue};
      if (issue) begin
        x1_q <= win_x;
        c1_q <= cand_q;
      end
      if (vld_pipe_q[0]) begin
        xors_q   <= x1_q;
        sum_q    <= pc;
        coords_q <= c1_q;
        bidx_q   <= idx_q;
      end
    end
  end

  assign xors        = xors_q;
  assign sum         = sum_q;
  assign out_coords  = coords_q;
  assign blk_index_o = bidx_q;
  assign sum_valid   = vld_pipe_q[1];

endmodule
